// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/write-back
// and counts retired instructions. Illegal opcodes or functs trap into a sticky HALT.
module multicycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        MemReq,
    output logic        MemWrite,
    output logic        IorD,
    output logic        IRWrEn,
    output logic        PCInc,
    output logic        PCSrc,
    output logic        PCLoad,
    output logic        RegWrEn,
    output logic        RegDst,
    output logic        MemToReg,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUCtl,
    output logic [3:0]  State,
    output logic        Halted,
    output logic [31:0] Retired
);
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_EXEC_R  = 4'd2;
    localparam logic [3:0] S_EXEC_I  = 4'd3;
    localparam logic [3:0] S_MEMADDR = 4'd4;
    localparam logic [3:0] S_MEMRD   = 4'd5;
    localparam logic [3:0] S_MEMWR   = 4'd6;
    localparam logic [3:0] S_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_JUMP    = 4'd9;
    localparam logic [3:0] S_HALT    = 4'd10;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    logic [3:0]  state_q, state_d;
    logic        memtoreg_q, memtoreg_d;
    logic        regdst_q, regdst_d;
    logic [31:0] retired_q, retired_d;

    logic        retire;
    logic        mem_req, mem_write, iord, ir_wr, pc_inc, pc_src, pc_load;
    logic        reg_wr, reg_dst, mem_to_reg;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_ctl;

    always_comb begin
        state_d    = state_q;
        memtoreg_d = memtoreg_q;
        regdst_d   = regdst_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_wr      = 1'b0;
        pc_inc     = 1'b0;
        pc_src     = 1'b0;
        pc_load    = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_b  = 2'd0;
        alu_ctl    = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (MemReady) begin
                    ir_wr   = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (Op)
                    6'h00:        state_d = S_EXEC_R;
                    6'h08:        state_d = S_EXEC_I;
                    6'h23, 6'h2B: state_d = S_MEMADDR;
                    6'h04:        state_d = S_BRANCH;
                    6'h02:        state_d = S_JUMP;
                    default:      state_d = S_HALT;
                endcase
            end
            S_EXEC_R: begin
                state_d    = S_WB;
                regdst_d   = 1'b1;
                memtoreg_d = 1'b0;
                case (Funct)
                    6'h20:   alu_ctl = ALU_ADD;
                    6'h22:   alu_ctl = ALU_SUB;
                    6'h24:   alu_ctl = ALU_AND;
                    6'h25:   alu_ctl = ALU_OR;
                    6'h2A:   alu_ctl = ALU_SLT;
                    default: begin
                        // Unknown funct traps before any register write.
                        state_d    = S_HALT;
                        regdst_d   = regdst_q;
                        memtoreg_d = memtoreg_q;
                    end
                endcase
            end
            S_EXEC_I: begin
                alu_src_b  = 2'd1;
                state_d    = S_WB;
                regdst_d   = 1'b0;
                memtoreg_d = 1'b0;
            end
            S_MEMADDR: begin
                alu_src_b = 2'd1;
                state_d   = (Op == 6'h2B) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (MemReady) begin
                    state_d    = S_WB;
                    memtoreg_d = 1'b1;
                    regdst_d   = 1'b0;
                end
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
                if (MemReady) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_WB: begin
                reg_wr     = 1'b1;
                reg_dst    = regdst_q;
                mem_to_reg = memtoreg_q;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_BRANCH: begin
                alu_ctl = ALU_SUB;
                pc_src  = Zero;
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_JUMP: begin
                pc_load = 1'b1;
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    assign retired_d = retired_q + {31'd0, retire};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            memtoreg_q <= 1'b0;
            regdst_q   <= 1'b0;
            retired_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            memtoreg_q <= memtoreg_d;
            regdst_q   <= regdst_d;
            retired_q  <= retired_d;
        end
    end

    // Gating with rst_n drops an in-flight memory request the moment reset asserts.
    assign MemReq   = mem_req & rst_n;
    assign MemWrite = mem_write & rst_n;
    assign IorD     = iord & rst_n;
    assign IRWrEn   = ir_wr & rst_n;
    assign PCInc    = pc_inc & rst_n;
    assign PCSrc    = pc_src & rst_n;
    assign PCLoad   = pc_load & rst_n;
    assign RegWrEn  = reg_wr & rst_n;
    assign RegDst   = reg_dst & rst_n;
    assign MemToReg = mem_to_reg & rst_n;
    assign ALUSrcB  = alu_src_b & {2{rst_n}};
    assign ALUCtl   = alu_ctl & {3{rst_n}};
    assign State    = state_q;
    assign Halted   = (state_q == S_HALT);
    assign Retired  = retired_q;
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL expose these ports (name  direction  width  meaning):
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- Op  in  6  opcode field of the instruction register
- Funct  in  6  function field of the instruction register
- Zero  in  1  ALU zero flag, valid during BRANCH
- MemReady  in  1  memory completion strobe
- MemReq  out  1  memory access request
- MemWrite  out  1  request is a write
- IorD  out  1  0 = address from PC, 1 = address from ALU
- IRWrEn  out  1  load instruction register
- PCInc  out  1  program counter advances by 4
- PCSrc  out  1  program counter adds (Imm<<2)
- PCLoad  out  1  program counter loads jump target (DIn)
- RegWrEn  out  1  register file write
- RegDst  out  1  1 = rd, 0 = rt
- MemToReg  out  1  1 = write-back from memory, 0 = from ALU
- ALUSrcB  out  2  0 = reg, 1 = sign-extended Imm
- ALUCtl  out  3  0 = ADD, 1 = SUB, 2 = AND, 3 = OR, 4 = SLT
- State  out  4  current state encoding
- Halted  out  1  illegal opcode trapped
- Retired  out  32  count of completed instructions

Function
REQ-003 SHALL implement these states: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEMADDR=4, MEMRD=5, MEMWR=6, WB=7, BRANCH=8, JUMP=9, HALT=10. Encodings 11-15 SHALL go to FETCH on the next edge.
REQ-004 FETCH:
- MemReq=1, IorD=0.
- While MemReady=0, SHALL hold in FETCH with IRWrEn=PCInc=0.
- On the MemReady=1 cycle, SHALL assert IRWrEn=1 and PCInc=1 combinationally, and go to DECODE.
REQ-005 DECODE: one cycle, all control outputs 0. Next state by Op:
- 0x00 -> EXEC_R
- 0x08 (addi) -> EXEC_I
- 0x23 (lw) or 0x2B (sw) -> MEMADDR
- 0x04 (beq) -> BRANCH
- 0x02 (j) -> JUMP
- any other Op -> HALT
REQ-006 EXEC_R:
- ALUSrcB=0.
- ALUCtl by Funct: 0x20 -> ADD, 0x22 -> SUB, 0x24 -> AND, 0x25 -> OR, 0x2A -> SLT.
- Any other Funct -> HALT without writing a register.
- Otherwise go to WB with RegDst=1.
REQ-007 EXEC_I: ALUSrcB=1, ALUCtl=ADD, then WB with RegDst=0.
REQ-008 MEMADDR: ALUSrcB=1, ALUCtl=ADD. Next is MEMRD for lw, MEMWR for sw.
REQ-009 MEMRD / MEMWR:
- MemReq=1, IorD=1; MemWrite=1 in MEMWR only.
- SHALL hold until MemReady=1.
- Then MEMRD -> WB (MemToReg=1, RegDst=0), MEMWR -> FETCH.
REQ-010 WB: RegWrEn=1 for exactly one cycle, then FETCH. MemToReg and RegDst SHALL be held from the originating path.
REQ-011 BRANCH: ALUSrcB=0, ALUCtl=SUB, PCSrc=Zero (combinational), then FETCH.
REQ-012 JUMP: PCLoad=1 for one cycle, then FETCH.
REQ-013 HALT: Halted=1, all other control outputs 0. HALT is sticky until reset.
REQ-014 At most one of PCInc, PCSrc, PCLoad SHALL be 1 in any cycle. Outputs not listed for a state SHALL be 0.
REQ-015 Retired SHALL increment by 1 on each edge leaving WB, BRANCH or JUMP, or leaving MEMWR for FETCH. It SHALL wrap 0xFFFFFFFF -> 0 and SHALL NOT increment in HALT.
REQ-016 MemReady outside FETCH, MEMRD and MEMWR SHALL be ignored.

Reset
REQ-017 When rst_n=0, SHALL immediately, independent of clk, force:
- State=FETCH, Retired=0, Halted=0
- all registered path flags (MemToReg, RegDst) to 0.
REQ-018 Reset asserted mid-access (MEMRD/MEMWR) SHALL drop MemReq in the same cycle with no write completion. After release, the first rising edge SHALL evaluate FETCH.

Verification
REQ-019 Bench SHALL cover:
- add (Op=0, Funct=0x20), MemReady=1 in the first cycle -> states 0,1,2,7,0; one RegWrEn with RegDst=1; Retired=1.
- lw with MemReady delayed 3 cycles in MEMRD -> MemReq held 4 cycles with IorD=1; WB has MemToReg=1; Retired increments once.
- beq with Zero=1, then beq with Zero=0 -> PCSrc=1 exactly one cycle in the first, 0 in the second; each takes 3 states (FETCH, DECODE, BRANCH).
- j -> PCLoad=1 for one cycle, PCInc=0 in that cycle.
- Op=0x3F -> HALT, Halted=1, outputs held 0 for 20 cycles; rst_n pulse -> FETCH, Halted=0.
- Retired preloaded via force to 0xFFFFFFFF, then one instruction -> Retired=0.
- rst_n=0 asserted between clock edges during MEMWR -> MemReq and MemWrite=0 before the next edge.
